// File: rtl/iir_coef_loader_if.sv
// Coefficient write bus: valid/ready word stream with a bank-start marker.
// The master drives words; the loader (slave) returns ready.
interface iir_coef_loader_if;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_first;
  logic [31:0] wr_data;

  modport master (output wr_valid, output wr_first, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_first, input wr_data, output wr_ready);
endinterface

// File: rtl/iir_coef_loader.sv
// Assembles five double-precision biquad coefficients from ten 32-bit words into
// a shadow bank and commits them atomically on a sample boundary.
module iir_coef_loader #(
  parameter int unsigned NEG_A        = 1,
  parameter int unsigned CHECK_FINITE = 1
) (
  input  logic                  clk_fast,
  input  logic                  rst_b,
  iir_coef_loader_if.slave      wr,
  input  logic                  sample_tick,
  output logic [63:0]           b0,
  output logic [63:0]           b1,
  output logic [63:0]           b2,
  output logic [63:0]           a1,
  output logic [63:0]           a2,
  output logic                  pending,
  output logic                  commit_pulse,
  output logic                  seq_err,
  output logic                  coef_err
);

  localparam logic [63:0] B0_RESET = 64'h3FF0_0000_0000_0000;
  localparam logic        NEG      = (NEG_A != 0);
  localparam logic        CHK      = (CHECK_FINITE != 0);

  typedef enum logic [1:0] {IDLE, LOAD, PENDING, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [31:0] shadow [10];
  logic        ready_q;
  logic        xfer;
  logic        bad_bank;

  logic        store;
  logic [3:0]  store_idx;
  logic        ready_nxt;
  logic        pending_nxt;
  logic        seq_nxt;
  logic        commit_nxt;
  logic        coef_nxt;

  assign wr.wr_ready = ready_q;
  assign xfer        = wr.wr_valid & ready_q;

  // Exponent field of each coefficient lives in bits [30:20] of its upper word.
  assign bad_bank = CHK & ((shadow[0][30:20] == 11'h7FF) |
                           (shadow[2][30:20] == 11'h7FF) |
                           (shadow[4][30:20] == 11'h7FF) |
                           (shadow[6][30:20] == 11'h7FF) |
                           (shadow[8][30:20] == 11'h7FF));

  always_ff @(posedge clk_fast or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && wr.wr_first) state_nxt = LOAD;
      LOAD:    if (xfer && !wr.wr_first && idx == 4'd9) state_nxt = PENDING;
      PENDING: if (sample_tick) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs are driven from next-state values so they align with the state.
  always_comb begin
    store       = 1'b0;
    store_idx   = idx;
    idx_nxt     = idx;
    seq_nxt     = 1'b0;
    commit_nxt  = 1'b0;
    coef_nxt    = 1'b0;
    ready_nxt   = (state_nxt == IDLE) || (state_nxt == LOAD);
    pending_nxt = (state_nxt == PENDING);
    case (state)
      IDLE: begin
        if (xfer) begin
          if (wr.wr_first) begin
            store     = 1'b1;
            store_idx = 4'd0;
            idx_nxt   = 4'd1;
          end else begin
            seq_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          store = 1'b1;
          if (wr.wr_first) begin
            store_idx = 4'd0;
            idx_nxt   = 4'd1;
            seq_nxt   = 1'b1;
          end else begin
            store_idx = idx;
            idx_nxt   = (idx == 4'd9) ? 4'd0 : idx + 4'd1;
          end
        end
      end
      PENDING: begin
        if (sample_tick) begin
          if (bad_bank) coef_nxt   = 1'b1;
          else          commit_nxt = 1'b1;
        end
      end
      COMMIT: idx_nxt = 4'd0;
      default: idx_nxt = 4'd0;
    endcase
  end

  always_ff @(posedge clk_fast or negedge rst_b) begin
    if (!rst_b) begin
      idx          <= '0;
      shadow       <= '{default: '0};
      ready_q      <= 1'b0;
      pending      <= 1'b0;
      seq_err      <= 1'b0;
      commit_pulse <= 1'b0;
      coef_err     <= 1'b0;
    end else begin
      idx          <= idx_nxt;
      ready_q      <= ready_nxt;
      pending      <= pending_nxt;
      seq_err      <= seq_nxt;
      commit_pulse <= commit_nxt;
      coef_err     <= coef_nxt;
      if (store) shadow[store_idx] <= wr.wr_data;
    end
  end

  // The biquad adds its a-terms, so the sign of a1/a2 is flipped here.
  always_ff @(posedge clk_fast or negedge rst_b) begin
    if (!rst_b) begin
      b0 <= B0_RESET;
      b1 <= '0;
      b2 <= '0;
      a1 <= '0;
      a2 <= '0;
    end else if (commit_nxt) begin
      b0 <= {shadow[0], shadow[1]};
      b1 <= {shadow[2], shadow[3]};
      b2 <= {shadow[4], shadow[5]};
      a1 <= {shadow[6][31] ^ NEG, shadow[6][30:0], shadow[7]};
      a2 <= {shadow[8][31] ^ NEG, shadow[8][30:0], shadow[9]};
    end
  end

endmodule

// File: tb/tb_iir_coef_loader.sv
// Directed bench for iir_coef_loader: bank loads, commit timing, sequencing
// errors, non-finite rejection and asynchronous reset.
module tb_iir_coef_loader;

  logic        clk_fast    = 1'b0;
  logic        rst_b       = 1'b0;
  logic        sample_tick = 1'b0;
  logic [63:0] b0, b1, b2, a1, a2;
  logic        pending, commit_pulse, seq_err, coef_err;

  int errors = 0;
  int checks = 0;

  logic [63:0] cur [5];

  iir_coef_loader_if wr_bus ();

  iir_coef_loader #(
    .NEG_A        (1),
    .CHECK_FINITE (1)
  ) dut (
    .clk_fast     (clk_fast),
    .rst_b        (rst_b),
    .wr           (wr_bus.slave),
    .sample_tick  (sample_tick),
    .b0           (b0),
    .b1           (b1),
    .b2           (b2),
    .a1           (a1),
    .a2           (a2),
    .pending      (pending),
    .commit_pulse (commit_pulse),
    .seq_err      (seq_err),
    .coef_err     (coef_err)
  );

  always #5 clk_fast = ~clk_fast;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_fast);
    #1;
  endtask

  task automatic send(input logic first, input logic [31:0] data);
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_first = first;
    wr_bus.wr_data  = data;
    step();
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_first = 1'b0;
  endtask

  function automatic logic [31:0] word(input int unsigned i);
    logic [63:0] c;
    c = cur[3'(i / 2)];
    return (i % 2 == 0) ? c[63:32] : c[31:0];
  endfunction

  task automatic send_range(input int unsigned lo, input int unsigned hi);
    for (int unsigned i = lo; i <= hi; i++) send(i == 0, word(i));
  endtask

  task automatic set_bank(input logic [63:0] c0, input logic [63:0] c1, input logic [63:0] c2,
                          input logic [63:0] c3, input logic [63:0] c4);
    cur[0] = c0; cur[1] = c1; cur[2] = c2; cur[3] = c3; cur[4] = c4;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic expect_active(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                               input logic [63:0] e2, input logic [63:0] e3, input logic [63:0] e4);
    check({tag, "_b0"}, b0, e0);
    check({tag, "_b1"}, b1, e1);
    check({tag, "_b2"}, b2, e2);
    check({tag, "_a1"}, a1, e3);
    check({tag, "_a2"}, a2, e4);
  endtask

  initial begin
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_first = 1'b0;
    wr_bus.wr_data  = '0;

    step();
    step();
    check("rst_ready_low", wr_bus.wr_ready, 0);
    check("rst_pending", pending, 0);
    expect_active("rst_hold", 64'h3FF0000000000000, 0, 0, 0, 0);
    rst_b = 1'b1;
    step();
    check("post_rst_ready", wr_bus.wr_ready, 1);
    check("post_rst_pending", pending, 0);
    expect_active("post_rst", 64'h3FF0000000000000, 0, 0, 0, 0);

    // Bank A: 0.5, 0.25, 0, 1.5, -0.5
    set_bank(64'h3FE0000000000000, 64'h3FD0000000000000, 64'h0,
             64'h3FF8000000000000, 64'hBFE0000000000000);
    send_range(0, 8);
    check("a_pend_early", pending, 0);
    send(1'b0, word(9));
    check("a_pending", pending, 1);
    check("a_ready_low", wr_bus.wr_ready, 0);
    check("a_b0_hold", b0, 64'h3FF0000000000000);
    step();
    step();
    check("a_pending_wait", pending, 1);
    check("a_no_commit_wait", commit_pulse, 0);
    tick();
    check("a_commit", commit_pulse, 1);
    check("a_pending_clr", pending, 0);
    expect_active("a_act", 64'h3FE0000000000000, 64'h3FD0000000000000, 64'h0,
                  64'hBFF8000000000000, 64'h3FE0000000000000);
    step();
    check("a_commit_1cyc", commit_pulse, 0);
    check("a_ready_back", wr_bus.wr_ready, 1);

    tick();
    check("idle_tick_commit", commit_pulse, 0);
    check("idle_tick_b0", b0, 64'h3FE0000000000000);

    // Bank B: 2.0, 1.0, 0.5, 0.25, -0.25; tick mid-load and on the last word
    set_bank(64'h4000000000000000, 64'h3FF0000000000000, 64'h3FE0000000000000,
             64'h3FD0000000000000, 64'hBFD0000000000000);
    send_range(0, 3);
    tick();
    check("load_tick_commit", commit_pulse, 0);
    check("load_tick_b0", b0, 64'h3FE0000000000000);
    send_range(4, 8);
    sample_tick = 1'b1;
    send(1'b0, word(9));
    sample_tick = 1'b0;
    check("b_w9tick_commit", commit_pulse, 0);
    check("b_w9tick_pending", pending, 1);
    check("b_w9tick_b0", b0, 64'h3FE0000000000000);
    step();
    check("b_still_pending", pending, 1);
    tick();
    check("b_commit", commit_pulse, 1);
    expect_active("b_act", 64'h4000000000000000, 64'h3FF0000000000000, 64'h3FE0000000000000,
                  64'hBFD0000000000000, 64'h3FD0000000000000);
    step();

    // Restart at index 5 with bank D: 0.75, 0, 0.25, -1.0, 0.125
    set_bank(64'h3FE0000000000000, 64'h3FD0000000000000, 64'h0,
             64'h3FF8000000000000, 64'hBFE0000000000000);
    send_range(0, 4);
    check("restart_seq_before", seq_err, 0);
    set_bank(64'h3FE8000000000000, 64'h0, 64'h3FD0000000000000,
             64'hBFF0000000000000, 64'h3FC0000000000000);
    send(1'b1, word(0));
    check("restart_seq_err", seq_err, 1);
    check("restart_pending", pending, 0);
    send_range(1, 8);
    check("restart_seq_clr", seq_err, 0);
    send(1'b0, word(9));
    check("d_pending", pending, 1);
    tick();
    check("d_commit", commit_pulse, 1);
    expect_active("d_act", 64'h3FE8000000000000, 64'h0, 64'h3FD0000000000000,
                  64'h3FF0000000000000, 64'hBFC0000000000000);
    step();

    send(1'b0, 32'h12345678);
    check("idle_drop_seq_err", seq_err, 1);
    check("idle_drop_pending", pending, 0);
    check("idle_drop_ready", wr_bus.wr_ready, 1);
    step();
    check("idle_drop_seq_1cyc", seq_err, 0);

    // Bank E has a1 = +Inf
    set_bank(64'h3FF0000000000000, 64'h0, 64'h0, 64'h7FF0000000000000, 64'h0);
    send_range(0, 9);
    check("e_pending", pending, 1);
    check("e_no_seq_err", seq_err, 0);
    tick();
    check("e_coef_err", coef_err, 1);
    check("e_no_commit", commit_pulse, 0);
    check("e_no_seq", seq_err, 0);
    expect_active("e_hold", 64'h3FE8000000000000, 64'h0, 64'h3FD0000000000000,
                  64'h3FF0000000000000, 64'hBFC0000000000000);
    step();
    check("e_coef_1cyc", coef_err, 0);
    check("e_pending_clr", pending, 0);

    step();
    set_bank(64'h3FE0000000000000, 64'h3FD0000000000000, 64'h0,
             64'h3FF8000000000000, 64'hBFE0000000000000);
    send_range(0, 9);
    check("r_pending", pending, 1);
    #1 rst_b = 1'b0;
    #1;
    expect_active("r_async", 64'h3FF0000000000000, 0, 0, 0, 0);
    check("r_async_pending", pending, 0);
    check("r_async_ready", wr_bus.wr_ready, 0);
    #2 rst_b = 1'b1;
    step();
    check("r_ready_back", wr_bus.wr_ready, 1);
    check("r_pending_after", pending, 0);
    tick();
    check("r_no_commit", commit_pulse, 0);
    check("r_b0_reset", b0, 64'h3FF0000000000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
